// File: rtl/sel_sequencer_if.sv
// rtl/sel_sequencer_if.sv - scan request inputs and select-code/status outputs of sel_sequencer
interface sel_sequencer_if #(
  parameter int DWELL_W = 4
);
  logic               start;
  logic               dir;
  logic [DWELL_W-1:0] dwell;
  logic               hold;
  logic [1:0]         A;
  logic               step;
  logic               busy;
  logic               done;

  // Requester side: issues scan passes and watches progress
  modport master (
    output start, dir, dwell, hold,
    input  A, step, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, dir, dwell, hold,
    output A, step, busy, done
  );
endinterface

// File: rtl/sel_sequencer.sv
// rtl/sel_sequencer.sv - four-code select scanner with per-code dwell and hold; SEL_SEQ_GRAY_EN selects Gray code order
module sel_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  sel_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         pos_q, pos_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               dir_q, dir_d;
  logic [1:0]         a_q, a_d;
  logic               step_q, step_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Maps scan position 0..3 to the select code; descending scans walk the ascending table backwards.
  function automatic logic [1:0] code_of(input logic d, input logic [1:0] pos);
    logic [1:0] p;
    p = d ? ~pos : pos;
`ifdef SEL_SEQ_GRAY_EN
    return {p[1], p[1] ^ p[0]};
`else
    return p;
`endif
  endfunction

  // State and registered outputs; reset takes effect without waiting for a clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= 2'd0;
      cnt_q   <= '0;
      dwell_q <= '0;
      dir_q   <= 1'b0;
      a_q     <= 2'b00;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      dir_q   <= dir_d;
      a_q     <= a_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output decode; step and done default low so they only ever pulse
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    dir_d   = dir_q;
    a_d     = a_q;
    step_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          pos_d   = 2'd0;
          cnt_d   = '0;
          dwell_d = bus.dwell;
          dir_d   = bus.dir;
          a_d     = code_of(bus.dir, 2'd0);
          step_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // hold freezes everything in place; the pass resumes exactly where it stopped
        if (!bus.hold) begin
          if (cnt_q == dwell_q) begin
            cnt_d = '0;
            if (pos_q == 2'd3) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              pos_d  = pos_q + 2'd1;
              a_d    = code_of(dir_q, pos_q + 2'd1);
              step_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.A    = a_q;
  assign bus.step = step_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_sel_sequencer.sv
// tb/tb_sel_sequencer.sv - directed self-checking bench for sel_sequencer
module tb_sel_sequencer;
  localparam int DWELL_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sel_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

  sel_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Ascending code table for the build under test
  function automatic logic [1:0] code_at(input logic d, input int k);
    logic [1:0] asc [4];
`ifdef SEL_SEQ_GRAY_EN
    asc = '{2'b00, 2'b01, 2'b11, 2'b10};
`else
    asc = '{2'b00, 2'b01, 2'b10, 2'b11};
`endif
    return d ? asc[3-k] : asc[k];
  endfunction

  // Expected {A, step, busy, done} at observed cycle t of a pass (t=0 is the first busy cycle).
  // Hold is high while cycles hs..hs+hl-1 are observed, freezing the following edge.
  function automatic logic [4:0] model(input logic d, input int dw, input int hs, input int hl, input int t);
    int p = dw + 1;
    int f = 0;
    int e;
    bit fr;
    for (int j = 1; j <= t; j++)
      if (j - 1 >= hs && j - 1 < hs + hl) f++;
    fr = (t > 0) && (t - 1 >= hs) && (t - 1 < hs + hl);
    e  = t - f;
    if (e < 4 * p)       return {code_at(d, e / p), ((e % p) == 0) && !fr, 1'b1, 1'b0};
    else if (e == 4 * p) return {code_at(d, 3), 3'b001};
    else                 return {code_at(d, 3), 3'b000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    bus.dwell = '0;
    bus.hold  = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.A, bus.step, bus.busy, bus.done} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_async got %b exp 00000", {bus.A, bus.step, bus.busy, bus.done});
    end
    bus.hold = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if ({bus.A, bus.step, bus.busy, bus.done} !== 5'b00000) begin
        errors++;
        $display("FAIL reset_idle_hold t=%0d got %b exp 00000", t, {bus.A, bus.step, bus.busy, bus.done});
      end
    end
    bus.hold = 1'b0;
  endtask

  task automatic test_asc_dwell0();
    int nb = 0, nd = 0;
    bus.dir = 1'b0; bus.dwell = 4'd0; bus.start = 1'b1;
    for (int t = 0; t < 7; t++) begin
      tick();
      bus.start = 1'b0;
      nb += int'(bus.busy); nd += int'(bus.done);
      checks++;
      if ({bus.A, bus.step, bus.busy, bus.done} !== model(1'b0, 0, -1, 0, t)) begin
        errors++;
        $display("FAIL asc_dwell0 t=%0d got %b exp %b", t, {bus.A, bus.step, bus.busy, bus.done}, model(1'b0, 0, -1, 0, t));
      end
    end
    checks++;
    if (nb !== 4 || nd !== 1) begin
      errors++;
      $display("FAIL asc_dwell0_len busy=%0d done=%0d exp busy=4 done=1", nb, nd);
    end
  endtask

  task automatic test_desc_dwell2();
    int nb = 0, nd = 0;
    bus.dir = 1'b1; bus.dwell = 4'd2; bus.start = 1'b1;
    for (int t = 0; t < 15; t++) begin
      tick();
      bus.start = 1'b0;
      nb += int'(bus.busy); nd += int'(bus.done);
      checks++;
      if ({bus.A, bus.step, bus.busy, bus.done} !== model(1'b1, 2, -1, 0, t)) begin
        errors++;
        $display("FAIL desc_dwell2 t=%0d got %b exp %b", t, {bus.A, bus.step, bus.busy, bus.done}, model(1'b1, 2, -1, 0, t));
      end
    end
    checks++;
    if (nb !== 12 || nd !== 1) begin
      errors++;
      $display("FAIL desc_dwell2_len busy=%0d done=%0d exp busy=12 done=1", nb, nd);
    end
  endtask

  task automatic test_hold();
    int nb = 0, nd = 0, ns = 0;
    bus.dir = 1'b0; bus.dwell = 4'd1; bus.start = 1'b1;
    for (int t = 0; t < 16; t++) begin
      tick();
      bus.start = 1'b0;
      nb += int'(bus.busy); nd += int'(bus.done); ns += int'(bus.step);
      checks++;
      if ({bus.A, bus.step, bus.busy, bus.done} !== model(1'b0, 1, 2, 5, t)) begin
        errors++;
        $display("FAIL hold t=%0d got %b exp %b", t, {bus.A, bus.step, bus.busy, bus.done}, model(1'b0, 1, 2, 5, t));
      end
      bus.hold = (t >= 2 && t < 7);
    end
    bus.hold = 1'b0;
    checks++;
    if (nb !== 13 || nd !== 1 || ns !== 4) begin
      errors++;
      $display("FAIL hold_len busy=%0d done=%0d steps=%0d exp 13 1 4", nb, nd, ns);
    end
  endtask

  task automatic test_back_to_back();
    int nb = 0, nd = 0;
    bus.dir = 1'b0; bus.dwell = 4'd3; bus.start = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      nb += int'(bus.busy); nd += int'(bus.done);
      checks++;
      if ({bus.A, bus.step, bus.busy, bus.done} !== model(1'b0, 3, -1, 0, t)) begin
        errors++;
        $display("FAIL back_to_back t=%0d got %b exp %b", t, {bus.A, bus.step, bus.busy, bus.done}, model(1'b0, 3, -1, 0, t));
      end
      bus.start = (t < 17);
      bus.dir   = ~bus.dir;
      bus.dwell = DWELL_W'(t);
    end
    checks++;
    if (nb !== 16 || nd !== 1) begin
      errors++;
      $display("FAIL back_to_back_len busy=%0d done=%0d exp busy=16 done=1", nb, nd);
    end
    bus.dir = 1'b0;
  endtask

  task automatic test_dwell_max();
    int nb = 0;
    bus.dir = 1'b1; bus.dwell = 4'hF; bus.start = 1'b1;
    for (int t = 0; t < 66; t++) begin
      tick();
      bus.start = 1'b0;
      nb += int'(bus.busy);
      checks++;
      if ({bus.A, bus.step, bus.busy, bus.done} !== model(1'b1, 15, -1, 0, t)) begin
        errors++;
        $display("FAIL dwell_max t=%0d got %b exp %b", t, {bus.A, bus.step, bus.busy, bus.done}, model(1'b1, 15, -1, 0, t));
      end
    end
    checks++;
    if (nb !== 64) begin
      errors++;
      $display("FAIL dwell_max_len busy=%0d exp 64", nb);
    end
  endtask

  task automatic test_reset_midpass();
    int nd = 0;
    bus.dir = 1'b1; bus.dwell = 4'd2; bus.start = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      bus.start = 1'b0;
    end
    checks++;
    if (bus.A !== code_at(1'b1, 1) || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midpass_pre A=%b busy=%b exp A=%b busy=1", bus.A, bus.busy, code_at(1'b1, 1));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.A, bus.step, bus.busy, bus.done} !== 5'b00000) begin
      errors++;
      $display("FAIL midpass_rst got %b exp 00000", {bus.A, bus.step, bus.busy, bus.done});
    end
    tick();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      nd += int'(bus.done);
      checks++;
      if ({bus.A, bus.step, bus.busy, bus.done} !== 5'b00000) begin
        errors++;
        $display("FAIL midpass_after t=%0d got %b exp 00000", t, {bus.A, bus.step, bus.busy, bus.done});
      end
    end
    bus.dir = 1'b0; bus.dwell = 4'd0; bus.start = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      bus.start = 1'b0;
      nd += int'(bus.done);
      checks++;
      if ({bus.A, bus.step, bus.busy, bus.done} !== model(1'b0, 0, -1, 0, t)) begin
        errors++;
        $display("FAIL midpass_fresh t=%0d got %b exp %b", t, {bus.A, bus.step, bus.busy, bus.done}, model(1'b0, 0, -1, 0, t));
      end
    end
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL midpass_done_count got %0d exp 1", nd);
    end
  endtask

  initial begin
    test_reset();
    test_asc_dwell0();
    tick();
    test_desc_dwell2();
    tick();
    test_hold();
    tick();
    test_back_to_back();
    tick();
    test_dwell_max();
    tick();
    test_reset_midpass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
